// File: rtl/store_data_align.sv
// Store data aligner: turns an LSU store into lane-aligned bus write beats.
// Optional MISALIGN_SPLIT_EN splits boundary-crossing stores into two beats.
module store_data_align #(
    parameter int XLEN = 64,
    parameter int AW   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AW-1:0]       req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [2:0]          req_func3,
    input  logic                req_is_cinstr,
    input  logic                flush,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [AW-1:0]       bus_addr,
    output logic [XLEN-1:0]     bus_wdata,
    output logic [XLEN/8-1:0]   bus_wstrb,
    output logic                st_done,
    output logic                st_exc,
    output logic [AW-1:0]       st_badaddr,
    output logic [1:0]          dbg_state
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
`ifdef MISALIGN_SPLIT_EN
    localparam logic [1:0] S_BEAT1 = 2'd2;
`endif
    localparam logic [1:0] S_EXC   = 2'd3;

    // Handshake: a beat transfers on a cycle where bus_valid && bus_ready;
    // bus_valid and its payload stay put until then. A request is taken on
    // req_valid && req_ready (req_ready is high only in IDLE).
    logic [1:0]      state;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] data_q;
    logic [1:0]      sz_q;
    logic            done_q;
    logic [1:0]      req_sz;
    logic            req_exc;
`ifdef MISALIGN_SPLIT_EN
    logic            cross_q;
    logic            req_cross;
`endif

    // Size kept as log2(bytes); compressed stores only encode word/double.
    always_comb begin
        req_sz  = req_is_cinstr ? {1'b1, req_func3[0]} : req_func3[1:0];
        req_exc = (!req_is_cinstr && req_func3[2]) || ((XLEN == 32) && (req_sz == 2'd3));
`ifdef MISALIGN_SPLIT_EN
        req_cross = (5'(req_addr[OFS-1:0]) + (5'd1 << req_sz)) > 5'(NB);
`else
        case (req_sz)
            2'd0:    req_exc = req_exc;
            2'd1:    req_exc = req_exc || req_addr[0];
            2'd2:    req_exc = req_exc || (|req_addr[1:0]);
            default: req_exc = req_exc || (|req_addr[2:0]);
        endcase
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
            data_q <= '0;
            sz_q   <= '0;
            done_q <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            cross_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        addr_q <= req_addr;
                        data_q <= req_wdata;
                        sz_q   <= req_sz;
`ifdef MISALIGN_SPLIT_EN
                        cross_q <= req_cross;
`endif
                        state  <= req_exc ? S_EXC : S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    // An accepted beat wins over a same-cycle flush.
                    if (bus_ready) begin
`ifdef MISALIGN_SPLIT_EN
                        if (cross_q) begin
                            state <= S_BEAT1;
                        end else begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
`else
                        state  <= S_IDLE;
                        done_q <= 1'b1;
`endif
                    end else if (flush) begin
                        state <= S_IDLE;
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                S_BEAT1: begin
                    if (bus_ready) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
`endif
                S_EXC:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [AW-1:0] base_addr;
`ifdef MISALIGN_SPLIT_EN
    logic [2*NB-1:0]   mask_ext;
    logic [2*NB-1:0]   strb_ext;
    logic [2*XLEN-1:0] data_ext;
`else
    logic [NB-1:0]     mask_nb;
    logic [NB-1:0]     strb_lo;
    logic [XLEN-1:0]   data_lo;
`endif

    // Shifting into a double-width window gives beat0 in the low half and
    // beat1 (the spill-over bytes) in the high half.
    always_comb begin
        base_addr = {addr_q[AW-1:OFS], {OFS{1'b0}}};
`ifdef MISALIGN_SPLIT_EN
        mask_ext = '0;
        for (int i = 0; i < 8; i++) mask_ext[i] = (i < (32'd1 << sz_q));
        strb_ext = mask_ext << addr_q[OFS-1:0];
        data_ext = {{XLEN{1'b0}}, data_q} << {addr_q[OFS-1:0], 3'b000};
`else
        mask_nb = '0;
        for (int i = 0; i < NB; i++) mask_nb[i] = (i < (32'd1 << sz_q));
        strb_lo = mask_nb << addr_q[OFS-1:0];
        data_lo = data_q << {addr_q[OFS-1:0], 3'b000};
`endif
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        bus_valid  = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_wstrb  = '0;
        st_exc     = 1'b0;
        st_badaddr = '0;
        case (state)
            S_BEAT0: begin
                bus_valid = 1'b1;
                bus_addr  = base_addr;
`ifdef MISALIGN_SPLIT_EN
                bus_wdata = data_ext[XLEN-1:0];
                bus_wstrb = strb_ext[NB-1:0];
`else
                bus_wdata = data_lo;
                bus_wstrb = strb_lo;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            S_BEAT1: begin
                bus_valid = 1'b1;
                bus_addr  = base_addr + AW'(NB);
                bus_wdata = data_ext[2*XLEN-1:XLEN];
                bus_wstrb = strb_ext[2*NB-1:NB];
            end
`endif
            S_EXC: begin
                st_exc     = !flush;
                st_badaddr = flush ? '0 : addr_q;
            end
            default: ;
        endcase
    end

    assign st_done   = done_q;
    assign dbg_state = state;
endmodule

// File: tb/tb_store_data_align.sv
// Directed self-checking bench for store_data_align (XLEN=64, AW=64).
module tb_store_data_align;
  localparam int XLEN = 64;
  localparam int AW   = 64;
  localparam int NB   = XLEN / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [AW-1:0]   req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic [2:0]      req_func3 = '0;
  logic            req_is_cinstr = 1'b0;
  logic            flush = 1'b0;
  logic            bus_valid;
  logic            bus_ready = 1'b0;
  logic [AW-1:0]   bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [NB-1:0]   bus_wstrb;
  logic            st_done;
  logic            st_exc;
  logic [AW-1:0]   st_badaddr;
  logic [1:0]      dbg_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  store_data_align #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_func3(req_func3), .req_is_cinstr(req_is_cinstr),
    .flush(flush),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .st_done(st_done), .st_exc(st_exc), .st_badaddr(st_badaddr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                          input logic [2:0] f3, input logic c);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_func3 = f3; req_is_cinstr = c;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    chk_cnt++; if (bus_valid !== 1'b0 || st_done !== 1'b0 || st_exc !== 1'b0)
      $display("FAIL reset_flags got v=%b d=%b e=%b exp 0/0/0", bus_valid, st_done, st_exc); else pass_cnt++;
    chk_cnt++; if (bus_addr !== '0 || bus_wdata !== '0 || bus_wstrb !== '0 || st_badaddr !== '0)
      $display("FAIL reset_payload got a=%h w=%h s=%h b=%h exp 0", bus_addr, bus_wdata, bus_wstrb, st_badaddr); else pass_cnt++;
    rst = 1'b0;
    step();
    chk_cnt++; if (req_ready !== 1'b1 || dbg_state !== 2'd0)
      $display("FAIL reset_ready got rdy=%b st=%0d exp 1/0", req_ready, dbg_state); else pass_cnt++;
    bus_ready = 1'b0;
    send_req(64'h1003, 64'hAB, 3'b000, 1'b0);
    chk_cnt++; if (bus_valid !== 1'b1)
      $display("FAIL reset_beat0_valid got %b exp 1", bus_valid); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    chk_cnt++; if (bus_valid !== 1'b0)
      $display("FAIL reset_async_drop got %b exp 0", bus_valid); else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    chk_cnt++; if (req_ready !== 1'b1 || st_done !== 1'b0 || bus_valid !== 1'b0 || bus_wstrb !== '0)
      $display("FAIL reset_after got rdy=%b d=%b v=%b s=%h exp 1/0/0/0", req_ready, st_done, bus_valid, bus_wstrb); else pass_cnt++;
  endtask

  task automatic test_byte_store();
    bus_ready = 1'b0;
    send_req(64'h1003, 64'hAB, 3'b000, 1'b0);
    chk_cnt++; if (bus_valid !== 1'b1 || bus_addr !== 64'h1000)
      $display("FAIL sb_addr got v=%b a=%h exp 1/1000", bus_valid, bus_addr); else pass_cnt++;
    chk_cnt++; if (bus_wdata !== 64'h0000_0000_AB00_0000 || bus_wstrb !== 8'h08)
      $display("FAIL sb_data got w=%h s=%h exp 00000000ab000000/08", bus_wdata, bus_wstrb); else pass_cnt++;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    chk_cnt++; if (st_done !== 1'b1 || bus_valid !== 1'b0)
      $display("FAIL sb_done got d=%b v=%b exp 1/0", st_done, bus_valid); else pass_cnt++;
    step();
    chk_cnt++; if (st_done !== 1'b0)
      $display("FAIL sb_done_pulse got %b exp 0", st_done); else pass_cnt++;
  endtask

  task automatic test_compressed();
    bus_ready = 1'b1;
    send_req(64'h2000, 64'h1122334455667788, 3'b111, 1'b1);
    chk_cnt++; if (bus_wstrb !== 8'hFF || bus_wdata !== 64'h1122334455667788 || bus_addr !== 64'h2000)
      $display("FAIL csd_beat got a=%h w=%h s=%h exp 2000/1122334455667788/ff", bus_addr, bus_wdata, bus_wstrb); else pass_cnt++;
    step();
    chk_cnt++; if (st_done !== 1'b1)
      $display("FAIL csd_done got %b exp 1", st_done); else pass_cnt++;
    send_req(64'h2000, 64'h1122334455667788, 3'b110, 1'b1);
    chk_cnt++; if (bus_wstrb !== 8'h0F || bus_wdata !== 64'h1122334455667788)
      $display("FAIL csw_beat got w=%h s=%h exp 1122334455667788/0f", bus_wdata, bus_wstrb); else pass_cnt++;
    step();
    bus_ready = 1'b0;
    chk_cnt++; if (st_done !== 1'b1)
      $display("FAIL csw_done got %b exp 1", st_done); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bus_ready = 1'b0;
    send_req(64'h3004, 64'hCAFEBABE, 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk_cnt++; if (bus_valid !== 1'b1 || bus_addr !== 64'h3000 || bus_wdata !== 64'hCAFEBABE_0000_0000 || bus_wstrb !== 8'hF0)
        $display("FAIL bp_stable cyc=%0d got v=%b a=%h w=%h s=%h exp 1/3000/cafebabe00000000/f0", i, bus_valid, bus_addr, bus_wdata, bus_wstrb);
      else pass_cnt++;
      step();
    end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    chk_cnt++; if (st_done !== 1'b1)
      $display("FAIL bp_done got %b exp 1", st_done); else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    bus_ready = 1'b1;
    send_req(64'h4000, 64'h77, 3'b000, 1'b0);
    step();
    chk_cnt++; if (st_done !== 1'b1 || req_ready !== 1'b1)
      $display("FAIL b2b_ready got d=%b rdy=%b exp 1/1", st_done, req_ready); else pass_cnt++;
    send_req(64'h4002, 64'h1234, 3'b001, 1'b0);
    chk_cnt++; if (bus_valid !== 1'b1 || bus_addr !== 64'h4000 || bus_wdata !== 64'h0000_0000_1234_0000 || bus_wstrb !== 8'h0C)
      $display("FAIL b2b_sh got v=%b a=%h w=%h s=%h exp 1/4000/12340000/0c", bus_valid, bus_addr, bus_wdata, bus_wstrb); else pass_cnt++;
    step();
    bus_ready = 1'b0;
    chk_cnt++; if (st_done !== 1'b1)
      $display("FAIL b2b_done got %b exp 1", st_done); else pass_cnt++;
    step();
  endtask

  task automatic test_flush();
    flush = 1'b1;
    send_req(64'h5000, 64'h99, 3'b000, 1'b0);
    chk_cnt++; if (bus_valid !== 1'b0 || st_exc !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL flush_idle got v=%b e=%b rdy=%b exp 0/0/1", bus_valid, st_exc, req_ready); else pass_cnt++;
    flush = 1'b0;
    bus_ready = 1'b0;
    send_req(64'h5000, 64'h0123456789ABCDEF, 3'b011, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_cnt++; if (bus_valid !== 1'b0 || st_done !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL flush_beat0 got v=%b d=%b rdy=%b exp 0/0/1", bus_valid, st_done, req_ready); else pass_cnt++;
    step();
    chk_cnt++; if (st_done !== 1'b0)
      $display("FAIL flush_beat0_nodone got %b exp 0", st_done); else pass_cnt++;
    send_req(64'h6007, 64'h5A, 3'b000, 1'b0);
    chk_cnt++; if (bus_wstrb !== 8'h80 || bus_wdata !== 64'h5A00_0000_0000_0000)
      $display("FAIL flush_rdy_beat got w=%h s=%h exp 5a00000000000000/80", bus_wdata, bus_wstrb); else pass_cnt++;
    flush = 1'b1; bus_ready = 1'b1;
    step();
    flush = 1'b0; bus_ready = 1'b0;
    chk_cnt++; if (st_done !== 1'b1)
      $display("FAIL flush_with_ready got %b exp 1", st_done); else pass_cnt++;
    step();
  endtask

`ifdef MISALIGN_SPLIT_EN
  task automatic test_split();
    bus_ready = 1'b0;
    send_req(64'h1006, 64'hDDCCBBAA, 3'b010, 1'b0);
    chk_cnt++; if (bus_addr !== 64'h1000 || bus_wstrb !== 8'hC0 || bus_wdata !== 64'hBBAA_0000_0000_0000)
      $display("FAIL split_b0 got a=%h w=%h s=%h exp 1000/bbaa000000000000/c0", bus_addr, bus_wdata, bus_wstrb); else pass_cnt++;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    chk_cnt++; if (bus_valid !== 1'b1 || bus_addr !== 64'h1008 || bus_wstrb !== 8'h03 || bus_wdata !== 64'hDDCC || st_done !== 1'b0)
      $display("FAIL split_b1 got v=%b a=%h w=%h s=%h d=%b exp 1/1008/ddcc/03/0", bus_valid, bus_addr, bus_wdata, bus_wstrb, st_done); else pass_cnt++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_cnt++; if (bus_valid !== 1'b1 || bus_addr !== 64'h1008)
      $display("FAIL split_flush_b1 got v=%b a=%h exp 1/1008", bus_valid, bus_addr); else pass_cnt++;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    chk_cnt++; if (st_done !== 1'b1)
      $display("FAIL split_done got %b exp 1", st_done); else pass_cnt++;
    send_req(64'hFFFF_FFFF_FFFF_FFFC, 64'h1122334455667788, 3'b011, 1'b0);
    chk_cnt++; if (bus_addr !== 64'hFFFF_FFFF_FFFF_FFF8 || bus_wstrb !== 8'hF0 || bus_wdata !== 64'h5566_7788_0000_0000)
      $display("FAIL wrap_b0 got a=%h w=%h s=%h exp fffffffffffffff8/5566778800000000/f0", bus_addr, bus_wdata, bus_wstrb); else pass_cnt++;
    bus_ready = 1'b1;
    step();
    chk_cnt++; if (bus_addr !== 64'h0 || bus_wstrb !== 8'h0F || bus_wdata !== 64'h1122_3344)
      $display("FAIL wrap_b1 got a=%h w=%h s=%h exp 0/11223344/0f", bus_addr, bus_wdata, bus_wstrb); else pass_cnt++;
    step();
    bus_ready = 1'b0;
    send_req(64'h1001, 64'hBEEF, 3'b001, 1'b0);
    chk_cnt++; if (bus_addr !== 64'h1000 || bus_wstrb !== 8'h06 || bus_wdata !== 64'hBE_EF00 || st_exc !== 1'b0)
      $display("FAIL misal_inwin got a=%h w=%h s=%h e=%b exp 1000/beef00/06/0", bus_addr, bus_wdata, bus_wstrb, st_exc); else pass_cnt++;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    chk_cnt++; if (st_done !== 1'b1 || bus_valid !== 1'b0)
      $display("FAIL misal_inwin_done got d=%b v=%b exp 1/0", st_done, bus_valid); else pass_cnt++;
    step();
  endtask
`else
  task automatic test_no_split();
    bus_ready = 1'b1;
    send_req(64'h1001, 64'h1234, 3'b001, 1'b0);
    chk_cnt++; if (st_exc !== 1'b1 || st_badaddr !== 64'h1001 || bus_valid !== 1'b0)
      $display("FAIL nosplit_exc got e=%b b=%h v=%b exp 1/1001/0", st_exc, st_badaddr, bus_valid); else pass_cnt++;
    step();
    chk_cnt++; if (st_exc !== 1'b0 || bus_valid !== 1'b0 || req_ready !== 1'b1 || st_done !== 1'b0)
      $display("FAIL nosplit_after got e=%b v=%b rdy=%b d=%b exp 0/0/1/0", st_exc, bus_valid, req_ready, st_done); else pass_cnt++;
    send_req(64'h1006, 64'hDDCCBBAA, 3'b010, 1'b0);
    chk_cnt++; if (st_exc !== 1'b1 || st_badaddr !== 64'h1006 || bus_valid !== 1'b0)
      $display("FAIL nosplit_sw got e=%b b=%h v=%b exp 1/1006/0", st_exc, st_badaddr, bus_valid); else pass_cnt++;
    step();
    send_req(64'h1001, 64'h1234, 3'b001, 1'b0);
    flush = 1'b1;
    #1;
    chk_cnt++; if (st_exc !== 1'b0)
      $display("FAIL nosplit_flush_exc got %b exp 0", st_exc); else pass_cnt++;
    flush = 1'b0;
    step();
    chk_cnt++; if (st_exc !== 1'b0 || bus_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL nosplit_flush_after got e=%b v=%b rdy=%b exp 0/0/1", st_exc, bus_valid, req_ready); else pass_cnt++;
    bus_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_byte_store();
    test_compressed();
    test_backpressure();
    test_back_to_back();
    test_flush();
`ifdef MISALIGN_SPLIT_EN
    test_split();
`else
    test_no_split();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
